// File: rtl/udma_i2c_arb_pkg.sv
// udma_i2c_arb_pkg
//   Shared definitions for the uDMA I2C command arbiter:
//   - arbiter state encoding
//   - position of the opcode field inside a 32-bit controller command word
//   - I2C controller opcode values (udma_i2c_control command set)
//   - helper that flags the opcodes which end a requester's ownership
package udma_i2c_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;

    localparam logic [3:0] I2C_CMD_START   = 4'h0;
    localparam logic [3:0] I2C_CMD_WAIT_EV = 4'h1;
    localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
    localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
    localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
    localparam logic [3:0] I2C_CMD_WR      = 4'h8;
    localparam logic [3:0] I2C_CMD_EOT     = 4'h9;
    localparam logic [3:0] I2C_CMD_WAIT    = 4'hA;
    localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
    localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

    // STOP and EOT close a transaction and hand the controller back.
    function automatic logic is_release_op(input logic [3:0] opc);
        return (opc == I2C_CMD_STOP) || (opc == I2C_CMD_EOT);
    endfunction

endpackage

// File: rtl/udma_i2c_rr_pick.sv
// udma_i2c_rr_pick
//   Combinational round-robin picker. Searches req upward starting at
//   last+1, wrapping modulo NB_REQ, and returns the first set index.
//   Ports:
//     req   in  NB_REQ  request vector
//     last  in  IDX_W   index granted most recently
//     found out 1       at least one request is set
//     idx   out IDX_W   selected index (0 when found is low)
module udma_i2c_rr_pick #(
    parameter int unsigned NB_REQ = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    int unsigned      c;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        cand  = '0;
        // last+k never exceeds 2*NB_REQ-1, so one subtraction wraps it.
        for (int unsigned k = 1; k <= NB_REQ; k++) begin
            c = 32'(last) + k;
            if (c >= NB_REQ) begin
                c = c - NB_REQ;
            end
            cand = IDX_W'(c);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/udma_i2c_cmd_arbiter.sv
// udma_i2c_cmd_arbiter
//   Shares one udma_i2c_control between NB_REQ uDMA requester groups.
//   Round-robin at transaction granularity: a granted requester owns the
//   controller until one of its STOP/EOT commands is accepted.
//   Ports:
//     clk_i, rstn_i, sw_rst_i          clock, async active-low reset, soft reset
//     req_cmd_*  (NB_REQ groups)       command streams from requesters
//     req_tx_*   (NB_REQ groups)       TX byte streams from requesters
//     req_rx_*                         RX byte stream back to the owner
//     req_eot_o                        end-of-transfer pulse to the owner
//     ctrl_*                           single port set towards the controller
//     owner_valid_o, owner_idx_o       current grant status
module udma_i2c_cmd_arbiter
    import udma_i2c_arb_pkg::*;
#(
    parameter int unsigned NB_REQ = 2,
    // derived from NB_REQ; leave at its default
    parameter int unsigned IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sw_rst_i,

    input  logic [NB_REQ*32-1:0]  req_cmd_i,
    input  logic [NB_REQ-1:0]     req_cmd_valid_i,
    output logic [NB_REQ-1:0]     req_cmd_ready_o,

    input  logic [NB_REQ*8-1:0]   req_tx_data_i,
    input  logic [NB_REQ-1:0]     req_tx_valid_i,
    output logic [NB_REQ-1:0]     req_tx_ready_o,

    output logic [7:0]            req_rx_data_o,
    output logic [NB_REQ-1:0]     req_rx_valid_o,
    input  logic [NB_REQ-1:0]     req_rx_ready_i,

    output logic [NB_REQ-1:0]     req_eot_o,

    output logic [31:0]           ctrl_cmd_o,
    output logic                  ctrl_cmd_valid_o,
    input  logic                  ctrl_cmd_ready_i,

    output logic [7:0]            ctrl_tx_data_o,
    output logic                  ctrl_tx_valid_o,
    input  logic                  ctrl_tx_ready_i,

    input  logic [7:0]            ctrl_rx_data_i,
    input  logic                  ctrl_rx_valid_i,
    output logic                  ctrl_rx_ready_o,

    input  logic                  ctrl_eot_i,

    output logic                  owner_valid_o,
    output logic [IDX_W-1:0]      owner_idx_o
);

    arb_state_e       state;
    logic [IDX_W-1:0] r_gnt;
    logic [IDX_W-1:0] r_last;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             release_beat;

    logic [31:0] cmd_arr [NB_REQ];
    logic [7:0]  tx_arr  [NB_REQ];

    for (genvar i = 0; i < NB_REQ; i++) begin : g_unpack
        assign cmd_arr[i] = req_cmd_i[32*i +: 32];
        assign tx_arr[i]  = req_tx_data_i[8*i +: 8];
    end

    udma_i2c_rr_pick #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (req_cmd_valid_i),
        .last  (r_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign release_beat = (state == ST_GRANT) && ctrl_cmd_valid_o && ctrl_cmd_ready_i &&
                          is_release_op(ctrl_cmd_o[OPC_MSB:OPC_LSB]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= ST_IDLE;
            r_gnt  <= '0;
            r_last <= IDX_W'(NB_REQ - 1);
        end else if (sw_rst_i) begin
            state  <= ST_IDLE;
            r_gnt  <= '0;
            r_last <= IDX_W'(NB_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        r_gnt <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_beat) begin
                        r_last <= r_gnt;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_rx_data_o = ctrl_rx_data_i;

    always_comb begin
        ctrl_cmd_o       = '0;
        ctrl_cmd_valid_o = 1'b0;
        ctrl_tx_data_o   = '0;
        ctrl_tx_valid_o  = 1'b0;
        ctrl_rx_ready_o  = 1'b0;
        req_cmd_ready_o  = '0;
        req_tx_ready_o   = '0;
        req_rx_valid_o   = '0;
        req_eot_o        = '0;
        owner_valid_o    = 1'b0;
        owner_idx_o      = '0;
        if (state == ST_GRANT) begin
            ctrl_cmd_o              = cmd_arr[r_gnt];
            ctrl_cmd_valid_o        = req_cmd_valid_i[r_gnt];
            req_cmd_ready_o[r_gnt]  = ctrl_cmd_ready_i;
            ctrl_tx_data_o          = tx_arr[r_gnt];
            ctrl_tx_valid_o         = req_tx_valid_i[r_gnt];
            req_tx_ready_o[r_gnt]   = ctrl_tx_ready_i;
            req_rx_valid_o[r_gnt]   = ctrl_rx_valid_i;
            ctrl_rx_ready_o         = req_rx_ready_i[r_gnt];
            req_eot_o[r_gnt]        = ctrl_eot_i;
            owner_valid_o           = 1'b1;
            owner_idx_o             = r_gnt;
        end
    end

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// tb_udma_i2c_cmd_arbiter
//   Directed scenarios followed by randomized traffic; every cycle all
//   outputs are compared with a transaction-level ownership model.
module tb_udma_i2c_cmd_arbiter;

    localparam int NB = 3;
    localparam int IW = 2;

    localparam logic [3:0] OP_START  = 4'h0;
    localparam logic [3:0] OP_STOP   = 4'h2;
    localparam logic [3:0] OP_RD_ACK = 4'h4;
    localparam logic [3:0] OP_WR     = 4'h8;
    localparam logic [3:0] OP_EOT    = 4'h9;

    logic              clk = 1'b0;
    logic              rstn;
    logic              sw_rst;
    logic [NB*32-1:0]  req_cmd;
    logic [NB-1:0]     req_cmd_valid;
    logic [NB-1:0]     req_cmd_ready;
    logic [NB*8-1:0]   req_tx_data;
    logic [NB-1:0]     req_tx_valid;
    logic [NB-1:0]     req_tx_ready;
    logic [7:0]        req_rx_data;
    logic [NB-1:0]     req_rx_valid;
    logic [NB-1:0]     req_rx_ready;
    logic [NB-1:0]     req_eot;
    logic [31:0]       ctrl_cmd;
    logic              ctrl_cmd_valid;
    logic              ctrl_cmd_ready;
    logic [7:0]        ctrl_tx_data;
    logic              ctrl_tx_valid;
    logic              ctrl_tx_ready;
    logic [7:0]        ctrl_rx_data;
    logic              ctrl_rx_valid;
    logic              ctrl_rx_ready;
    logic              ctrl_eot;
    logic              owner_valid;
    logic [IW-1:0]     owner_idx;

    int checks   = 0;
    int failures = 0;
    int m_owner  = -1;
    int m_last   = NB - 1;

    always #5 clk = ~clk;

    udma_i2c_cmd_arbiter #(.NB_REQ(NB)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .sw_rst_i         (sw_rst),
        .req_cmd_i        (req_cmd),
        .req_cmd_valid_i  (req_cmd_valid),
        .req_cmd_ready_o  (req_cmd_ready),
        .req_tx_data_i    (req_tx_data),
        .req_tx_valid_i   (req_tx_valid),
        .req_tx_ready_o   (req_tx_ready),
        .req_rx_data_o    (req_rx_data),
        .req_rx_valid_o   (req_rx_valid),
        .req_rx_ready_i   (req_rx_ready),
        .req_eot_o        (req_eot),
        .ctrl_cmd_o       (ctrl_cmd),
        .ctrl_cmd_valid_o (ctrl_cmd_valid),
        .ctrl_cmd_ready_i (ctrl_cmd_ready),
        .ctrl_tx_data_o   (ctrl_tx_data),
        .ctrl_tx_valid_o  (ctrl_tx_valid),
        .ctrl_tx_ready_i  (ctrl_tx_ready),
        .ctrl_rx_data_i   (ctrl_rx_data),
        .ctrl_rx_valid_i  (ctrl_rx_valid),
        .ctrl_rx_ready_o  (ctrl_rx_ready),
        .ctrl_eot_i       (ctrl_eot),
        .owner_valid_o    (owner_valid),
        .owner_idx_o      (owner_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NB-1:0] v, input int last);
        for (int k = 1; k <= NB; k++) begin
            if (v[(last + k) % NB]) return (last + k) % NB;
        end
        return -1;
    endfunction

    // Expected outputs: owner sees the controller, everyone else sees zeros.
    task automatic check_outputs();
        logic [NB-1:0] e_crdy, e_trdy, e_rxv, e_eot;
        logic [31:0]   e_cmd;
        logic [7:0]    e_tx;
        logic          own, e_cv, e_tv, e_rr;
        int            o;
        own = (m_owner >= 0);
        o = own ? m_owner : 0;
        e_crdy = '0; e_trdy = '0; e_rxv = '0; e_eot = '0;
        e_cmd = '0; e_tx = '0; e_cv = 1'b0; e_tv = 1'b0; e_rr = 1'b0;
        if (own) begin
            e_cmd     = req_cmd[32*o +: 32];
            e_cv      = req_cmd_valid[o];
            e_crdy[o] = ctrl_cmd_ready;
            e_tx      = req_tx_data[8*o +: 8];
            e_tv      = req_tx_valid[o];
            e_trdy[o] = ctrl_tx_ready;
            e_rxv[o]  = ctrl_rx_valid;
            e_rr      = req_rx_ready[o];
            e_eot[o]  = ctrl_eot;
        end
        chk("owner_valid",    32'(owner_valid),    32'(own));
        chk("owner_idx",      32'(owner_idx),      32'(o));
        chk("ctrl_cmd",       ctrl_cmd,            e_cmd);
        chk("ctrl_cmd_valid", 32'(ctrl_cmd_valid), 32'(e_cv));
        chk("req_cmd_ready",  32'(req_cmd_ready),  32'(e_crdy));
        chk("ctrl_tx_data",   32'(ctrl_tx_data),   32'(e_tx));
        chk("ctrl_tx_valid",  32'(ctrl_tx_valid),  32'(e_tv));
        chk("req_tx_ready",   32'(req_tx_ready),   32'(e_trdy));
        chk("req_rx_valid",   32'(req_rx_valid),   32'(e_rxv));
        chk("ctrl_rx_ready",  32'(ctrl_rx_ready),  32'(e_rr));
        chk("req_eot",        32'(req_eot),        32'(e_eot));
        chk("req_rx_data",    32'(req_rx_data),    32'(ctrl_rx_data));
    endtask

    // Ownership rules: claim when idle, give back on an accepted STOP/EOT.
    task automatic model_update();
        logic [3:0] op;
        int p;
        if (!rstn || sw_rst) begin
            m_owner = -1;
            m_last  = NB - 1;
        end else if (m_owner < 0) begin
            p = pick(req_cmd_valid, m_last);
            if (p >= 0) m_owner = p;
        end else begin
            op = req_cmd[32*m_owner + 28 +: 4];
            if (req_cmd_valid[m_owner] && ctrl_cmd_ready && (op == OP_STOP || op == OP_EOT)) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic v);
        logic [27:0] low;
        low = 28'($urandom);
        req_cmd[32*i +: 32] = {op, low};
        req_cmd_valid[i] = v;
    endtask

    int          exp_seq [7] = '{0, -1, 1, -1, 2, -1, 0};
    logic [3:0]  ops [5]     = '{OP_START, OP_STOP, OP_RD_ACK, OP_WR, OP_EOT};

    initial begin
        rstn = 1'b0; sw_rst = 1'b0;
        req_cmd = '0; req_cmd_valid = '0; req_tx_data = '0; req_tx_valid = '0;
        req_rx_ready = '0; ctrl_cmd_ready = 1'b0; ctrl_tx_ready = 1'b0;
        ctrl_rx_data = 8'h5A; ctrl_rx_valid = 1'b0; ctrl_eot = 1'b0;
        step();
        step();
        chk("reset_owner_valid", 32'(owner_valid), 32'd0);
        rstn = 1'b1;

        // Single requester: START, WR 0xA5, STOP with an always-ready controller.
        ctrl_cmd_ready = 1'b1; ctrl_tx_ready = 1'b1;
        set_req(0, OP_START, 1'b1);
        step();
        chk("s1_grant_latency", 32'(owner_valid), 32'd1);
        step();
        set_req(0, OP_WR, 1'b1);
        req_tx_data[7:0] = 8'hA5; req_tx_valid[0] = 1'b1;
        #1;
        chk("s1_tx_byte", 32'(ctrl_tx_data), 32'h0000_00A5);
        step();
        set_req(0, OP_STOP, 1'b1);
        req_tx_valid[0] = 1'b0;
        step();
        req_cmd_valid = '0;
        #1;
        chk("s1_release", 32'(owner_valid), 32'd0);
        step();

        // Soft reset restores priority to requester 0, then full-load rotation.
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        for (int i = 0; i < NB; i++) set_req(i, OP_STOP, 1'b1);
        for (int s = 0; s < 7; s++) begin
            step();
            chk("fair_valid", 32'(owner_valid), 32'(exp_seq[s] >= 0));
            if (exp_seq[s] >= 0) chk("fair_idx", 32'(owner_idx), 32'(exp_seq[s]));
        end
        step();
        req_cmd_valid = '0;

        // Requester 1 reads a byte.
        ctrl_cmd_ready = 1'b0;
        set_req(1, OP_RD_ACK, 1'b1);
        step();
        ctrl_rx_valid = 1'b1; ctrl_rx_data = 8'h3C; req_rx_ready = 3'b011;
        #1;
        chk("rx_valid_vec", 32'(req_rx_valid), 32'b010);
        chk("rx_data", 32'(req_rx_data), 32'h3C);
        chk("rx_ready", 32'(ctrl_rx_ready), 32'd1);
        step();
        ctrl_rx_valid = 1'b0;

        // Soft reset mid-transaction, then requester 0 wins.
        sw_rst = 1'b1;
        set_req(0, OP_START, 1'b1);
        step();
        chk("swrst_owner_valid", 32'(owner_valid), 32'd0);
        sw_rst = 1'b0;
        step();
        chk("swrst_regrant_idx", 32'(owner_idx), 32'd0);

        // EOT command with the controller's eot pulse in the handshake cycle.
        set_req(0, OP_EOT, 1'b1);
        ctrl_cmd_ready = 1'b1; ctrl_eot = 1'b1;
        #1;
        chk("eot_vec", 32'(req_eot), 32'b001);
        step();
        ctrl_eot = 1'b0;
        req_cmd_valid[0] = 1'b0;
        #1;
        chk("eot_release", 32'(owner_valid), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NB; i++) set_req(i, ops[$urandom_range(0, 4)], 1'($urandom_range(0, 2) != 0));
            req_tx_data    = NB*8'($urandom);
            req_tx_valid   = NB'($urandom);
            req_rx_ready   = NB'($urandom);
            ctrl_cmd_ready = 1'($urandom);
            ctrl_tx_ready  = 1'($urandom);
            ctrl_rx_data   = 8'($urandom);
            ctrl_rx_valid  = 1'($urandom);
            ctrl_eot       = 1'($urandom);
            sw_rst         = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
